// File: rtl/hc_serial_rx_pkg.sv
// hc_pkg: shared definitions for the Hamming serial receive path.
//   - codeword position indices (c1=p1, c2=p2, c3=d1, c4=p4, c5=d2, c6=d3, c7=d4)
//   - hc_cw_w(): codeword width (8 with overall parity c0, 7 without)
//   - hc_entry_t: one decoded output entry {data, err, dbl}
//   - hc_syndrome(): {s4,s2,s1} over a codeword indexed by position
package hc_pkg;

  localparam int unsigned P1 = 1;
  localparam int unsigned P2 = 2;
  localparam int unsigned D1 = 3;
  localparam int unsigned P4 = 4;
  localparam int unsigned D2 = 5;
  localparam int unsigned D3 = 6;
  localparam int unsigned D4 = 7;

  typedef struct packed {
    logic [3:0] data;
    logic       err;
    logic       dbl;
  } hc_entry_t;

  function automatic int unsigned hc_cw_w(input int unsigned secded);
    return (secded != 0) ? 8 : 7;
  endfunction

  function automatic logic [2:0] hc_syndrome(input logic [7:0] cw);
    hc_syndrome = {cw[P4] ^ cw[D2] ^ cw[D3] ^ cw[D4],
                   cw[P2] ^ cw[D1] ^ cw[D3] ^ cw[D4],
                   cw[P1] ^ cw[D1] ^ cw[D2] ^ cw[D4]};
  endfunction

endpackage

// File: rtl/hc_serial_rx_if.sv
// hc_serial_rx_if: serial input and decoded-nibble output handshake of hc_serial_rx.
//   i_bit/i_bit_vld/i_sync : serial codeword bits, first-bit marker
//   o_data/o_err_flag/o_dbl_err/o_vld, i_rdy : valid/ready stream of decoded entries
//   slave  : receiver side (the decoder)
//   master : line driver and nibble consumer side
interface hc_serial_rx_if;
  logic       i_bit;
  logic       i_bit_vld;
  logic       i_sync;
  logic [3:0] o_data;
  logic       o_err_flag;
  logic       o_dbl_err;
  logic       o_vld;
  logic       i_rdy;

  modport slave (
    input  i_bit, i_bit_vld, i_sync, i_rdy,
    output o_data, o_err_flag, o_dbl_err, o_vld
  );

  modport master (
    output i_bit, i_bit_vld, i_sync, i_rdy,
    input  o_data, o_err_flag, o_dbl_err, o_vld
  );
endinterface

// File: rtl/hc_sync_fifo.sv
// hc_sync_fifo: synchronous FIFO of DEPTH entries of type T (DEPTH power of 2, >= 2).
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   wr_en_i/wr_data_i : push request; accepted when not full or when a pop happens the same cycle
//   rd_en_i        : pop the head (ignored when empty)
//   rd_data_o      : head entry, all zeros when empty
//   full_o/empty_o : occupancy flags
module hc_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic [7:0]
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic wr_en_i,
  input  T     wr_data_i,
  input  logic rd_en_i,
  output T     rd_data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_wr, do_rd;

  always_comb begin
    full_o    = (cnt_q == (AW+1)'(DEPTH));
    empty_o   = (cnt_q == '0);
    do_rd     = rd_en_i && !empty_o;
    do_wr     = wr_en_i && (!full_o || do_rd);
    rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_wr && !do_rd)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (do_rd && !do_wr) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/hc_serial_rx.sv
// hc_serial_rx: bit-serial Hamming(7,4) / SECDED(8,4) receiver.
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   bus (slave)    : serial bits in (i_bit, i_bit_vld, i_sync), decoded stream out
//                    (o_data, o_err_flag, o_dbl_err, o_vld, i_rdy)
//   o_ovf          : sticky, a decoded word was dropped on a full FIFO
//   o_corr_cnt     : saturating count of corrected words
//   o_uncorr_cnt   : saturating count of uncorrectable words
//   i_clr_cnt      : synchronous clear of both counters and o_ovf
// Path: deserializer -> codeword register -> decode (comb) -> FIFO write.
module hc_serial_rx
  import hc_pkg::*;
#(
  parameter int unsigned SECDED = 1,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  hc_serial_rx_if.slave    bus,
  output logic             o_ovf,
  output logic [CNT_W-1:0] o_corr_cnt,
  output logic [CNT_W-1:0] o_uncorr_cnt,
  input  logic             i_clr_cnt
);

  localparam int unsigned CW_W  = hc_cw_w(SECDED);
  // Position of the first serial bit: c0 with SECDED, c1 without.
  localparam int unsigned FIRST = (SECDED != 0) ? 0 : 1;

  logic [2:0]       bcnt_q, bcnt_d, idx;
  logic [7:0]       word_q, word_d;
  logic [7:0]       cw_q, cw_d;
  logic             cw_vld_q, cw_vld_d;
  logic [2:0]       syn;
  logic             par;
  logic [7:0]       fixed;
  hc_entry_t        entry, head;
  logic             fifo_full, fifo_empty, pop;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] corr_q, corr_d, unc_q, unc_d;

  // Deserializer: bits land directly at their codeword position; the
  // completed word is handed to the decode register with no bubble.
  always_comb begin
    bcnt_d   = bcnt_q;
    word_d   = word_q;
    cw_d     = cw_q;
    cw_vld_d = 1'b0;
    idx      = bus.i_sync ? '0 : bcnt_q;
    if (bus.i_bit_vld) begin
      if (bus.i_sync) word_d = '0;
      word_d[idx + 3'(FIRST)] = bus.i_bit;
      if (idx == 3'(CW_W - 1)) begin
        cw_d     = word_d;
        cw_vld_d = 1'b1;
        bcnt_d   = '0;
        word_d   = '0;
      end else begin
        bcnt_d = idx + 3'd1;
      end
    end
  end

  // Decode: with SECDED an odd overall parity means a single error at
  // position syn (syn=0 is c0 itself); even parity with syn!=0 is a double.
  always_comb begin
    syn   = hc_syndrome(cw_q);
    par   = ^cw_q;
    fixed = cw_q;
    entry = '0;
    if (SECDED != 0) begin
      if (par) begin
        fixed[syn] = ~fixed[syn];
        entry.err  = 1'b1;
      end else if (syn != '0) begin
        entry.dbl  = 1'b1;
      end
    end else if (syn != '0) begin
      fixed[syn] = ~fixed[syn];
      entry.err  = 1'b1;
    end
    entry.data = {fixed[D4], fixed[D3], fixed[D2], fixed[D1]};
  end

  assign pop = !fifo_empty && bus.i_rdy;

  always_comb begin
    ovf_d  = ovf_q;
    corr_d = corr_q;
    unc_d  = unc_q;
    if (i_clr_cnt) begin
      ovf_d  = 1'b0;
      corr_d = '0;
      unc_d  = '0;
    end else if (cw_vld_q) begin
      if (fifo_full && !pop)               ovf_d  = 1'b1;
      if (entry.err && (corr_q != '1))     corr_d = corr_q + CNT_W'(1);
      if (entry.dbl && (unc_q != '1))      unc_d  = unc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bcnt_q   <= '0;
      word_q   <= '0;
      cw_q     <= '0;
      cw_vld_q <= 1'b0;
      ovf_q    <= 1'b0;
      corr_q   <= '0;
      unc_q    <= '0;
    end else begin
      bcnt_q   <= bcnt_d;
      word_q   <= word_d;
      cw_q     <= cw_d;
      cw_vld_q <= cw_vld_d;
      ovf_q    <= ovf_d;
      corr_q   <= corr_d;
      unc_q    <= unc_d;
    end
  end

  hc_sync_fifo #(
    .DEPTH (DEPTH),
    .T     (hc_entry_t)
  ) u_fifo (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .wr_en_i   (cw_vld_q),
    .wr_data_i (entry),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign bus.o_data     = head.data;
  assign bus.o_err_flag = head.err;
  assign bus.o_dbl_err  = head.dbl;
  assign bus.o_vld      = !fifo_empty;
  assign o_ovf          = ovf_q;
  assign o_corr_cnt     = corr_q;
  assign o_uncorr_cnt   = unc_q;

endmodule
